wishbone_packet_master: RTL and testbench

WISHBONE_PACKET_MASTER -- requirements
Module: wishbone_packet_master

---
 rtl/wishbone_packet_master.sv | 152 +++++++++++++++
 tb/tb_wishbone_packet_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_packet_master.sv
// Wishbone packet master: moves up to MAX_PAYLOAD words between the payload buses and the bus.
// Define WB_MASTER_TIMEOUT_EN to abort a word after MAX_WAIT cycles without ack_i.
module wishbone_packet_master #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = 1,
    parameter int MAX_WAIT      = 8,
    parameter int MAX_PAYLOAD   = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    output logic [ADDRESS_WIDTH-1:0]          adr_o,
    input  logic [DATA_WIDTH-1:0]             dat_i,
    output logic [DATA_WIDTH-1:0]             dat_o,
    output logic                              we_o,
    output logic [DATA_BYTES-1:0]             sel_o,
    output logic                              stb_o,
    input  logic                              cyc_i,
    output logic                              cyc_o,
    input  logic                              ack_i,
    output logic [2:0]                        cti_o,
    input  logic [ADDRESS_WIDTH-1:0]          transfer_address,
    input  logic [MAX_PAYLOAD*DATA_WIDTH-1:0] payload_in,
    output logic [MAX_PAYLOAD*DATA_WIDTH-1:0] payload_out,
    input  logic [7:0]                        payload_length,
    input  logic                              start_read,
    output logic                              read_busy,
    input  logic                              start_write,
    output logic                              write_busy,
    output logic                              completed,
    output logic                              timeout
);

    typedef enum logic [1:0] {IDLE, ARB, ACTIVE, END} state_t;

    state_t                            state, state_d;
    logic [ADDRESS_WIDTH-1:0]          lat_addr;
    logic [MAX_PAYLOAD*DATA_WIDTH-1:0] lat_payload;
    logic [7:0]                        lat_len;
    logic                              lat_read;
    logic                              aborted;
    logic [7:0]                        word_idx;
    logic [7:0]                        clamp_len;
    logic                              start_any;
    logic                              active;
    logic                              last_word;
    logic                              wait_expired;
    logic [DATA_WIDTH-1:0]             wr_word;

    assign start_any = start_read || start_write;
    assign clamp_len = (payload_length > 8'(MAX_PAYLOAD)) ? 8'(MAX_PAYLOAD) : payload_length;
    assign active    = (state == ACTIVE);
    assign last_word = (word_idx == lat_len - 8'd1);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    logic [WCW-1:0] wait_cnt;

    // Counts unacknowledged cycles of the current word only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            wait_cnt <= '0;
        else if (!active || ack_i)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign wait_expired = active && !ack_i && (wait_cnt == WCW'(MAX_WAIT - 1));
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state;
        case (state)
            IDLE:    if (start_any) state_d = (clamp_len == 8'd0) ? END : ARB;
            ARB:     if (!cyc_i) state_d = ACTIVE;
            ACTIVE:  if ((ack_i && last_word) || wait_expired) state_d = END;
            END:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // NOTE: latched request and read-back words are reset too; a reset must leave no stale data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_payload <= '0;
            lat_len     <= '0;
            lat_read    <= 1'b0;
            aborted     <= 1'b0;
            word_idx    <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && start_any) begin
                lat_addr    <= transfer_address;
                lat_payload <= payload_in;
                lat_len     <= clamp_len;
                lat_read    <= start_read;
                aborted     <= 1'b0;
                word_idx    <= '0;
            end else if (active) begin
                if (ack_i)
                    word_idx <= word_idx + 8'd1;
                else if (wait_expired)
                    aborted <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            payload_out <= '0;
        end else if (active && ack_i && lat_read) begin
            for (int i = 0; i < MAX_PAYLOAD; i++)
                if (word_idx == 8'(i))
                    payload_out[i*DATA_WIDTH +: DATA_WIDTH] <= dat_i;
        end
    end

    always_comb begin
        wr_word = '0;
        for (int i = 0; i < MAX_PAYLOAD; i++)
            if (word_idx == 8'(i))
                wr_word = lat_payload[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Bus outputs are gated by ACTIVE so the bus is quiet in every other state.
    assign cyc_o = active;
    assign stb_o = active;
    assign we_o  = active && !lat_read;
    assign sel_o = active ? '1 : '0;
    assign adr_o = active ? lat_addr + ADDRESS_WIDTH'(word_idx) : '0;
    assign dat_o = (active && !lat_read) ? wr_word : '0;
    assign cti_o = !active          ? 3'b000 :
                   (lat_len == 8'd1) ? 3'b000 :
                   last_word         ? 3'b111 : 3'b010;

    assign read_busy  = lat_read && (state == ARB || active);
    assign write_busy = !lat_read && (state == ARB || active);
    assign completed  = (state == END) && !aborted;
`ifdef WB_MASTER_TIMEOUT_EN
    assign timeout    = (state == END) && aborted;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_packet_master.sv
// Randomised bench for wishbone_packet_master against a transfer-level model of the packet rules.
// Timeout coverage is built only when WB_MASTER_TIMEOUT_EN is defined.
module tb_wishbone_packet_master;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MP = 3;

    typedef struct packed {
        logic [15:0] adr;
        logic        we;
        logic [7:0]  dat;
        logic [2:0]  cti;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_i;
    logic [DW-1:0] dat_o;
    logic          we_o;
    logic [0:0]    sel_o;
    logic          stb_o;
    logic          cyc_i;
    logic          cyc_o;
    logic          ack_i;
    logic [2:0]    cti_o;
    logic [AW-1:0] transfer_address;
    logic [23:0]   payload_in;
    logic [23:0]   payload_out;
    logic [7:0]    payload_length;
    logic          start_read;
    logic          read_busy;
    logic          start_write;
    logic          write_busy;
    logic          completed;
    logic          timeout;

    wishbone_packet_master #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(1), .MAX_WAIT(8), .MAX_PAYLOAD(MP)
    ) dut (
        .clk_i(clk), .rst_i(rst), .adr_o(adr_o), .dat_i(dat_i), .dat_o(dat_o), .we_o(we_o),
        .sel_o(sel_o), .stb_o(stb_o), .cyc_i(cyc_i), .cyc_o(cyc_o), .ack_i(ack_i), .cti_o(cti_o),
        .transfer_address(transfer_address), .payload_in(payload_in), .payload_out(payload_out),
        .payload_length(payload_length), .start_read(start_read), .read_busy(read_busy),
        .start_write(start_write), .write_busy(write_busy), .completed(completed), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: memory indexed by the low address bits, ack after ack_delay wait cycles.
    logic [7:0] slave_mem [16];
    int         ack_delay = 0;
    bit         no_ack    = 1'b0;
    int         scnt      = 0;

    always @(posedge clk) begin
        if (!stb_o || ack_i) scnt <= 0;
        else                 scnt <= scnt + 1;
    end

    always @(negedge clk) begin
        #2;
        ack_i = stb_o && !no_ack && (scnt >= ack_delay);
        dat_i = stb_o ? slave_mem[adr_o[3:0]] : 8'h00;
    end

    // Transfer-level model: expected word list per transfer plus the read-back image.
    word_t       exp_words [MP];
    int          exp_n   = 0;
    int          xfer_id = 0;
    int          seen_id = 0;
    int          head    = 99;
    int          n_acks  = 0;
    logic [23:0] model_pout = '0;
    word_t       obs [8];

    always @(posedge clk) begin
        if (rst) begin
            model_pout <= '0;
            head       <= 99;
        end else if (xfer_id != seen_id) begin
            seen_id <= xfer_id;
            head    <= 0;
        end else if (timeout) begin
            head <= 99;
        end else if (stb_o && ack_i) begin
            if (head < 8) obs[head] <= '{adr_o, we_o, dat_o, cti_o};
            if (head < exp_n && !exp_words[head].we) model_pout[head*8 +: 8] <= dat_i;
            head   <= head + 1;
            n_acks <= n_acks + 1;
        end
    end

    int    n_completed  = 0;
    int    n_timeout    = 0;
    int    wbusy_cycles = 0;
    word_t e;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_bus", {cyc_o, stb_o, adr_o, dat_o, we_o, sel_o, cti_o}, '0);
            check("rst_flags", {read_busy, write_busy, completed, timeout}, '0);
            check("rst_payload_out", payload_out, '0);
        end else begin
            if (write_busy) wbusy_cycles++;
            if (stb_o) begin
                if (head < exp_n) begin
                    e = exp_words[head];
                    check("adr_o", adr_o, e.adr);
                    check("we_o", we_o, e.we);
                    check("dat_o", dat_o, e.dat);
                    check("cti_o", cti_o, e.cti);
                    check("sel_cyc", {sel_o, cyc_o}, 2'b11);
                    check("busy", {read_busy, write_busy}, {~e.we, e.we});
                end else begin
                    check("unexpected_stb", stb_o, 1'b0);
                end
            end else begin
                check("bus_idle", {cyc_o, adr_o, dat_o, we_o, sel_o, cti_o}, '0);
            end
            check("payload_out", payload_out, model_pout);
            if (completed) begin
                n_completed++;
                check("done_words", head, exp_n);
                check("done_flags", {read_busy, write_busy, timeout}, '0);
            end
            if (timeout) begin
                n_timeout++;
                check("timeout_flags", {read_busy, write_busy, completed}, '0);
            end
`ifndef WB_MASTER_TIMEOUT_EN
            check("timeout_tied", timeout, 1'b0);
`endif
        end
    end

    task automatic start_xfer(input bit rd, input logic [15:0] addr, input logic [7:0] len,
                              input logic [23:0] pay, input int dly, input int hold);
        int n;
        n = (len > 8'd3) ? 3 : int'(len);
        for (int k = 0; k < n; k++) begin
            exp_words[k].adr = addr + 16'(k);
            exp_words[k].we  = !rd;
            exp_words[k].dat = rd ? 8'h00 : pay[k*8 +: 8];
            exp_words[k].cti = (n == 1) ? 3'b000 : ((k == n - 1) ? 3'b111 : 3'b010);
        end
        exp_n     = n;
        xfer_id   = xfer_id + 1;
        ack_delay = dly;
        @(negedge clk); #1;
        cyc_i            = (hold > 0);
        start_read       = rd;
        start_write      = !rd;
        transfer_address = addr;
        payload_in       = pay;
        payload_length   = len;
        @(negedge clk); #1;
        start_read  = 1'b0;
        start_write = 1'b0;
    endtask

    task automatic run_xfer(input bit rd, input logic [15:0] addr, input logic [7:0] len,
                            input logic [23:0] pay, input int dly, input int hold, output int cycles);
        int c0, t0, a0, n;
        c0 = n_completed; t0 = n_timeout; a0 = n_acks;
        n  = (len > 8'd3) ? 3 : int'(len);
        start_xfer(rd, addr, len, pay, dly, hold);
        cycles = 0;
        for (int i = 0; i < 300 && n_completed == c0 && n_timeout == t0; i++) begin
            if (i == hold) cyc_i = 1'b0;
            @(negedge clk);
            if (i < hold) check("cyc_o_yield", cyc_o, 1'b0);
            cycles++;
        end
        cyc_i = 1'b0;
        check("xfer_completed", n_completed - c0, 1);
        check("xfer_word_count", n_acks - a0, n);
        repeat (3) @(negedge clk);
        check("single_pulse", {n_completed - c0, n_timeout - t0}, {32'd1, 32'd0});
    endtask

    int cyc_cnt;

    initial begin
        rst = 1'b1; cyc_i = 1'b0; start_read = 1'b0; start_write = 1'b0;
        transfer_address = '0; payload_in = '0; payload_length = '0;
        ack_i = 1'b0; dat_i = '0;
        for (int i = 0; i < 16; i++) slave_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs", {cyc_o, stb_o, adr_o, payload_out, completed, timeout}, '0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Three-word read with one wait cycle per word.
        slave_mem[0] = 8'h11; slave_mem[1] = 8'h22; slave_mem[2] = 8'h33;
        run_xfer(1'b1, 16'h0100, 8'd3, 24'h0, 1, 0, cyc_cnt);
        check("r3_adr", {obs[0].adr, obs[1].adr, obs[2].adr}, 48'h0100_0101_0102);
        check("r3_cti", {obs[0].cti, obs[1].cti, obs[2].cti}, 9'b010_010_111);
        check("r3_payload_out", payload_out, 24'h332211);
        check("r3_read_busy", read_busy, 1'b0);

        // Two-word write with immediate ack must leave payload_out alone.
        begin
            int wb0;
            wb0 = wbusy_cycles;
            run_xfer(1'b0, 16'h0040, 8'd2, 24'h00BEEF, 0, 0, cyc_cnt);
            check("w2_dat", {obs[0].dat, obs[1].dat}, 16'hEFBE);
            check("w2_we", {obs[0].we, obs[1].we}, 2'b11);
            check("w2_payload_out", payload_out, 24'h332211);
            check("w2_busy_seen", wbusy_cycles > wb0, 1'b1);
            check("w2_busy_low", write_busy, 1'b0);
        end

        // Bus held by another master for five cycles.
        run_xfer(1'b1, 16'h0010, 8'd2, 24'h0, 0, 5, cyc_cnt);

        // Zero length finishes quickly without a bus cycle; oversize length is clamped.
        run_xfer(1'b1, 16'h0020, 8'd0, 24'h0, 0, 0, cyc_cnt);
        check("len0_fast", cyc_cnt <= 3, 1'b1);
        begin
            int a0;
            a0 = n_acks;
            run_xfer(1'b0, 16'h0030, 8'd5, 24'hA1B2C3, 1, 0, cyc_cnt);
            check("len5_words", n_acks - a0, 3);
        end

        // Reset while the second word is on the bus.
        begin
            int c0, t0;
            bit found;
            c0 = n_completed; t0 = n_timeout; found = 1'b0;
            start_xfer(1'b1, 16'h0200, 8'd3, 24'h0, 2, 0);
            for (int i = 0; i < 50 && !found; i++) begin
                @(negedge clk);
                found = stb_o && (adr_o == 16'h0201);
            end
            check("rst_found_word2", found, 1'b1);
            #1 rst = 1'b1;
            #1;
            check("rst_mid_bus", {cyc_o, stb_o, read_busy, write_busy}, 4'b0000);
            check("rst_mid_payload", payload_out, 24'h0);
            repeat (2) @(negedge clk);
            #1 rst = 1'b0;
            repeat (10) @(negedge clk);
            check("rst_no_pulses", {n_completed - c0, n_timeout - t0}, 64'd0);
        end

        // Randomised transfers, including address wrap and clamped lengths.
        for (int t = 0; t < 30; t++) begin
            bit          rd;
            logic [15:0] addr;
            logic [7:0]  len;
            for (int i = 0; i < 16; i++) slave_mem[i] = 8'($urandom);
            rd   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            len  = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 5));
            run_xfer(rd, addr, len, 24'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), cyc_cnt);
        end

`ifdef WB_MASTER_TIMEOUT_EN
        // No ack: the word is abandoned after MAX_WAIT cycles.
        begin
            int c0, t0, stb_cycles;
            c0 = n_completed; t0 = n_timeout; stb_cycles = 0;
            no_ack = 1'b1;
            start_xfer(1'b1, 16'h0300, 8'd2, 24'h0, 0, 0);
            for (int i = 0; i < 20 && !stb_o; i++) @(negedge clk);
            for (int i = 0; i < 50 && stb_o; i++) begin
                stb_cycles++;
                @(negedge clk);
            end
            check("to_stb_cycles", stb_cycles, 8);
            repeat (3) @(negedge clk);
            check("to_pulses", {n_timeout - t0, n_completed - c0}, {32'd1, 32'd0});
            check("to_read_busy", read_busy, 1'b0);
            no_ack = 1'b0;
        end
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
